xprog_fetch: RTL and testbench

XPROG_FETCH -- requirements
Module: xprog_fetch

---
 rtl/xprog_fetch.sv | 158 +++++++++++++++
 tb/tb_xprog_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/xprog_fetch.sv
// Instruction fetch unit: synchronous ROM plus dual-port RAM, with an optional
// boot copy of the ROM image into RAM and a shared CPU/DMA port on the RAM.
//
// state   | meaning
// ST_BOOT | copying ROM[0..BOOT_WORDS-1] into RAM, port B owned by the copier
// ST_RUN  | normal operation, fetch and CPU/DMA accesses served
module xprog_fetch #(
  parameter int INSTR_W    = 32,
  parameter int ROM_ADDR_W = 9,
  parameter int RAM_ADDR_W = 9,
  parameter int BOOT_COPY  = 1,
  parameter int BOOT_WORDS = 16,
  localparam int PC_W      = 1 + ((ROM_ADDR_W > RAM_ADDR_W) ? ROM_ADDR_W : RAM_ADDR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_fetch_req,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instr_valid,
  output logic               o_busy,
  input  logic               i_data_sel,
  input  logic               i_data_we,
  input  logic [RAM_ADDR_W-1:0] i_data_addr,
  input  logic [INSTR_W-1:0] i_data_in,
  output logic [INSTR_W-1:0] o_data_out,
  output logic               o_data_ready,
  input  logic               i_dma_sel,
  input  logic               i_dma_we,
  input  logic [RAM_ADDR_W-1:0] i_dma_addr,
  input  logic [INSTR_W-1:0] i_dma_data_in,
  output logic [INSTR_W-1:0] o_dma_data_out,
  output logic               o_dma_ready
);

  localparam int CNT_W = $clog2(BOOT_WORDS + 1);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  // ROM image is a fixed address-derived pattern so the array maps to plain logic
  function automatic logic [INSTR_W-1:0] rom_word(input logic [ROM_ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a) * 32'h0101_0101 + 32'hC0DE_0000;
    return INSTR_W'(w);
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_boot_cnt;
  logic [INSTR_W-1:0]      r_boot_data;
  logic [INSTR_W-1:0]      r_ram [0:(1<<RAM_ADDR_W)-1];
  logic [INSTR_W-1:0]      r_instruction;
  logic                    r_instr_valid;
  logic [INSTR_W-1:0]      r_data_out;
  logic [INSTR_W-1:0]      r_dma_data_out;

  logic                    w_run;
  logic                    w_b_we;
  logic [RAM_ADDR_W-1:0]   w_b_addr;
  logic [INSTR_W-1:0]      w_b_wdata;
  logic                    w_data_ready;
  logic                    w_dma_ready;
  logic [RAM_ADDR_W-1:0]   w_fetch_ram_addr;
  logic [INSTR_W-1:0]      w_fetch_ram_word;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (BOOT_COPY != 0) ? ST_BOOT : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_b_we       = 1'b0;
    w_b_addr     = '0;
    w_b_wdata    = '0;
    w_data_ready = 1'b0;
    w_dma_ready  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Write lags the ROM read by one cycle; count 0 has nothing to write yet
        w_b_we    = (r_boot_cnt != '0);
        w_b_addr  = RAM_ADDR_W'(r_boot_cnt - 1'b1);
        w_b_wdata = r_boot_data;
        if (r_boot_cnt == CNT_W'(BOOT_WORDS)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_data_ready = i_data_sel;
        w_dma_ready  = i_dma_sel & ~i_data_sel;
        if (i_data_sel) begin
          w_b_we    = i_data_we;
          w_b_addr  = i_data_addr;
          w_b_wdata = i_data_in;
        end else begin
          w_b_we    = i_dma_sel & i_dma_we;
          w_b_addr  = i_dma_addr;
          w_b_wdata = i_dma_data_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot_cnt  <= '0;
      r_boot_data <= '0;
    end else if (r_state == ST_BOOT && r_boot_cnt != CNT_W'(BOOT_WORDS)) begin
      r_boot_cnt  <= r_boot_cnt + 1'b1;
      r_boot_data <= rom_word(ROM_ADDR_W'(r_boot_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (w_b_we) begin
      r_ram[w_b_addr] <= w_b_wdata;
    end
  end

  // Port A sees a same-cycle port B write to its address (write-first)
  assign w_fetch_ram_addr = i_pc[RAM_ADDR_W-1:0];
  assign w_fetch_ram_word = (w_b_we && w_b_addr == w_fetch_ram_addr) ? w_b_wdata
                                                                     : r_ram[w_fetch_ram_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction  <= '0;
      r_instr_valid  <= 1'b0;
      r_data_out     <= '0;
      r_dma_data_out <= '0;
    end else begin
      r_instr_valid <= w_run & i_fetch_req;
      if (w_run && i_fetch_req) begin
        r_instruction <= i_pc[PC_W-1] ? w_fetch_ram_word : rom_word(i_pc[ROM_ADDR_W-1:0]);
      end
      if (w_data_ready && !i_data_we) begin
        r_data_out <= r_ram[w_b_addr];
      end
      if (w_dma_ready && !i_dma_we) begin
        r_dma_data_out <= r_ram[w_b_addr];
      end
    end
  end

  assign o_instruction  = r_instruction;
  assign o_instr_valid  = r_instr_valid;
  assign o_busy         = (r_state == ST_BOOT);
  assign o_data_out     = r_data_out;
  assign o_data_ready   = w_data_ready;
  assign o_dma_data_out = r_dma_data_out;
  assign o_dma_ready    = w_dma_ready;

endmodule

// File: tb/tb_xprog_fetch.sv
// Directed bench for xprog_fetch: boot copy, fetch regions, port B arbitration,
// write-first fetch and mid-boot reset. ROM[a] = a*0x01010101 + 0xC0DE0000.
module tb_xprog_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [9:0]  pc = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        busy;
  logic        data_sel = 1'b0, data_we = 1'b0;
  logic [8:0]  data_addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_ready;
  logic        dma_sel = 1'b0, dma_we = 1'b0;
  logic [8:0]  dma_addr = '0;
  logic [31:0] dma_data_in = '0;
  logic [31:0] dma_data_out;
  logic        dma_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xprog_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fetch_req    (fetch_req),
    .i_pc           (pc),
    .o_instruction  (instruction),
    .o_instr_valid  (instr_valid),
    .o_busy         (busy),
    .i_data_sel     (data_sel),
    .i_data_we      (data_we),
    .i_data_addr    (data_addr),
    .i_data_in      (data_in),
    .o_data_out     (data_out),
    .o_data_ready   (data_ready),
    .i_dma_sel      (dma_sel),
    .i_dma_we       (dma_we),
    .i_dma_addr     (dma_addr),
    .i_dma_data_in  (dma_data_in),
    .o_dma_data_out (dma_data_out),
    .o_dma_ready    (dma_ready)
  );

  typedef struct {
    logic        fr;
    logic [9:0]  pc;
    logic        ds, dw;
    logic [8:0]  da;
    logic [31:0] di;
    logic        ms, mw;
    logic [8:0]  ma;
    logic [31:0] mi;
    logic        e_dr, e_mr, e_iv;
    logic [31:0] e_instr, e_dout, e_mout;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mv(logic fr, logic [9:0] p, logic ds, logic dw, logic [8:0] da,
                              logic [31:0] di, logic ms, logic mw, logic [8:0] ma, logic [31:0] mi,
                              logic edr, logic emr, logic eiv, logic [31:0] ei,
                              logic [31:0] ed, logic [31:0] em);
    vec_t v;
    v.fr = fr; v.pc = p; v.ds = ds; v.dw = dw; v.da = da; v.di = di;
    v.ms = ms; v.mw = mw; v.ma = ma; v.mi = mi;
    v.e_dr = edr; v.e_mr = emr; v.e_iv = eiv;
    v.e_instr = ei; v.e_dout = ed; v.e_mout = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; pc = '0;
    data_sel = 1'b0; data_we = 1'b0; data_addr = '0; data_in = '0;
    dma_sel = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_data_in = '0;
  endtask

  // Counts busy cycles after reset release while hammering fetch and both ports.
  task automatic boot_window(input string tag);
    int k;
    k = 0;
    fetch_req = 1'b1; pc = 10'h205;
    data_sel = 1'b1; data_we = 1'b0; data_addr = 9'd0;
    dma_sel = 1'b1; dma_we = 1'b0; dma_addr = 9'd1;
    while (busy && k < 40) begin
      chk({tag, "_boot_iv"}, 32'(instr_valid), 32'd0);
      chk({tag, "_boot_dr"}, 32'(data_ready), 32'd0);
      chk({tag, "_boot_mr"}, 32'(dma_ready), 32'd0);
      step();
      k++;
    end
    idle_inputs();
    chk({tag, "_busy_cycles"}, 32'(k), 32'd17);
    chk({tag, "_boot_dout"}, data_out, 32'h0);
    chk({tag, "_boot_mout"}, dma_data_out, 32'h0);
  endtask

  task automatic fetch_one(input string name, input logic [9:0] p, input logic [31:0] exp);
    fetch_req = 1'b1; pc = p;
    step();
    fetch_req = 1'b0;
    chk({name, "_iv"}, 32'(instr_valid), 32'd1);
    chk(name, instruction, exp);
  endtask

  initial begin
    //          fr pc       ds dw da     di            ms mw ma     mi            dr mr iv instr         dout          mout
    vecs[0]  = mv(1, 10'h005, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 1, 32'hC5E30505, 32'h0,        32'h0);
    vecs[1]  = mv(1, 10'h205, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 1, 32'hC5E30505, 32'h0,        32'h0);
    vecs[2]  = mv(1, 10'h200, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 1, 32'hC0DE0000, 32'h0,        32'h0);
    vecs[3]  = mv(1, 10'h20F, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 1, 32'hCFED0F0F, 32'h0,        32'h0);
    vecs[4]  = mv(0, 10'h001, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 0, 32'hCFED0F0F, 32'h0,        32'h0);
    vecs[5]  = mv(1, 10'h005, 1, 1, 9'd5,  32'h55AA0005, 0, 0, 9'd0,  32'h0,        1, 0, 1, 32'hC5E30505, 32'h0,        32'h0);
    vecs[6]  = mv(1, 10'h205, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 1, 32'h55AA0005, 32'h0,        32'h0);
    vecs[7]  = mv(0, 10'h000, 1, 1, 9'd3,  32'hDEADBEEF, 1, 0, 9'd7,  32'h0,        1, 0, 0, 32'h55AA0005, 32'h0,        32'h0);
    vecs[8]  = mv(0, 10'h000, 0, 0, 9'd0,  32'h0,        1, 0, 9'd7,  32'h0,        0, 1, 0, 32'h55AA0005, 32'h0,        32'hC7E50707);
    vecs[9]  = mv(0, 10'h000, 1, 0, 9'd3,  32'h0,        0, 0, 9'd0,  32'h0,        1, 0, 0, 32'h55AA0005, 32'hDEADBEEF, 32'hC7E50707);
    vecs[10] = mv(1, 10'h209, 1, 1, 9'd9,  32'h12345678, 0, 0, 9'd0,  32'h0,        1, 0, 1, 32'h12345678, 32'hDEADBEEF, 32'hC7E50707);
    vecs[11] = mv(0, 10'h000, 0, 0, 9'd0,  32'h0,        1, 1, 9'd20, 32'h0BADF00D, 0, 1, 0, 32'h12345678, 32'hDEADBEEF, 32'hC7E50707);
    vecs[12] = mv(0, 10'h000, 1, 0, 9'd20, 32'h0,        0, 0, 9'd0,  32'h0,        1, 0, 0, 32'h12345678, 32'h0BADF00D, 32'hC7E50707);
    vecs[13] = mv(1, 10'h014, 0, 0, 9'd0,  32'h0,        1, 0, 9'd9,  32'h0,        0, 1, 1, 32'hD4F21414, 32'h0BADF00D, 32'h12345678);
    vecs[14] = mv(1, 10'h214, 1, 0, 9'd20, 32'h0,        1, 1, 9'd20, 32'hFFFFFFFF, 1, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 32'h12345678);
    vecs[15] = mv(1, 10'h214, 0, 0, 9'd0,  32'h0,        1, 1, 9'd20, 32'hFFFFFFFF, 0, 1, 1, 32'hFFFFFFFF, 32'h0BADF00D, 32'h12345678);
    vecs[16] = mv(0, 10'h000, 0, 0, 9'd0,  32'h0,        0, 0, 9'd0,  32'h0,        0, 0, 0, 32'hFFFFFFFF, 32'h0BADF00D, 32'h12345678);

    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_dout", data_out, 32'h0);
    chk("rst_mout", dma_data_out, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    boot_window("b1");

    foreach (vecs[i]) begin
      fetch_req = vecs[i].fr; pc = vecs[i].pc;
      data_sel = vecs[i].ds; data_we = vecs[i].dw; data_addr = vecs[i].da; data_in = vecs[i].di;
      dma_sel = vecs[i].ms; dma_we = vecs[i].mw; dma_addr = vecs[i].ma; dma_data_in = vecs[i].mi;
      #2;
      chk($sformatf("v%0d_data_ready", i), 32'(data_ready), 32'(vecs[i].e_dr));
      chk($sformatf("v%0d_dma_ready", i), 32'(dma_ready), 32'(vecs[i].e_mr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d_instruction", i), instruction, vecs[i].e_instr);
      chk($sformatf("v%0d_data_out", i), data_out, vecs[i].e_dout);
      chk($sformatf("v%0d_dma_data_out", i), dma_data_out, vecs[i].e_mout);
    end
    idle_inputs();

    // Reset pulse at boot count 8: outputs clear at once and the copy restarts.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr", instruction, 32'h0);
    chk("mid_rst_iv", 32'(instr_valid), 32'd0);
    chk("mid_rst_dout", data_out, 32'h0);
    chk("mid_rst_mout", dma_data_out, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    step();
    rst_n = 1'b1;
    boot_window("b2");

    fetch_one("recopy_ram5", 10'h205, 32'hC5E30505);
    fetch_one("ram20_kept", 10'h214, 32'hFFFFFFFF);
    fetch_one("ram15_copy", 10'h20F, 32'hCFED0F0F);
    fetch_one("rom2", 10'h002, 32'hC2E00202);
    step();
    chk("final_iv_low", 32'(instr_valid), 32'd0);
    chk("final_instr_hold", instruction, 32'hC2E00202);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
